// File: rtl/video_pkg.sv
// Shared raster timing constants and types for the video pipeline.
// Defaults describe a 384x264 total raster with a 256x224 visible window.
package video_pkg;

   localparam int unsigned HTIMING_W = 10;
   localparam int unsigned VTIMING_W = 9;

   localparam int unsigned H_TOTAL      = 768;
   localparam int unsigned H_SYNC_START = 608;
   localparam int unsigned H_SYNC_END   = 672;
   localparam int unsigned V_TOTAL      = 264;
   localparam int unsigned V_ACT_START  = 16;
   localparam int unsigned V_ACT_END    = 240;
   localparam int unsigned V_SYNC_START = 248;
   localparam int unsigned V_SYNC_END   = 251;
   localparam int unsigned BLK2_DELAY   = 16;

   typedef enum logic [0:0] {
      IDLE,
      PENDING
   } nmi_state_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with a reset preset value; shifts every clock.
// The output is the input delayed by exactly Depth cycles.
module delay_line #(
   parameter int unsigned      Width  = 1,
   parameter int unsigned      Depth  = 16,
   parameter logic [Width-1:0] Preset = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] sr_q [Depth];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            sr_q[i] <= Preset;
         end
      end else begin
         sr_q[0] <= d_i;
         for (int unsigned i = 1; i < Depth; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   assign q_o = sr_q[Depth-1];

endmodule

// File: rtl/video_timing.sv
// Master raster timing generator: half-pixel/line counters, blanking, syncs,
// frame-stable flip and the VBLANK NMI latch.
module video_timing #(
   parameter int unsigned H_TOTAL      = video_pkg::H_TOTAL,
   parameter int unsigned H_SYNC_START = video_pkg::H_SYNC_START,
   parameter int unsigned H_SYNC_END   = video_pkg::H_SYNC_END,
   parameter int unsigned V_TOTAL      = video_pkg::V_TOTAL,
   parameter int unsigned V_ACT_START  = video_pkg::V_ACT_START,
   parameter int unsigned V_ACT_END    = video_pkg::V_ACT_END,
   parameter int unsigned V_SYNC_START = video_pkg::V_SYNC_START,
   parameter int unsigned V_SYNC_END   = video_pkg::V_SYNC_END,
   parameter int unsigned BLK2_DELAY   = video_pkg::BLK2_DELAY
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flip_ena,
   input  logic       nmi_ena,
   output logic [9:0] htiming,
   output logic [8:0] vtiming,
   output logic [7:0] vtiming_f,
   output logic       flip_q,
   output logic       hblk,
   output logic       vblk,
   output logic       cmpblk,
   output logic       cmpblk2,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       frame_start,
   output logic       nmi_n
);

   import video_pkg::*;

   if (!(H_TOTAL > 512 && H_TOTAL <= 1024)) begin : g_bad_h_total
      $error("video_timing: H_TOTAL must lie in (512, 1024]");
   end
   if (!(V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL)) begin : g_bad_vsync
      $error("video_timing: need V_SYNC_START < V_SYNC_END <= V_TOTAL");
   end
   if (!(V_ACT_START < V_ACT_END && V_ACT_END <= V_TOTAL)) begin : g_bad_vact
      $error("video_timing: need V_ACT_START < V_ACT_END <= V_TOTAL");
   end
   if (BLK2_DELAY < 1) begin : g_bad_blk2
      $error("video_timing: BLK2_DELAY must be at least 1");
   end

   localparam logic [HTIMING_W-1:0] HLast      = HTIMING_W'(H_TOTAL - 1);
   localparam logic [HTIMING_W-1:0] HSyncStart = HTIMING_W'(H_SYNC_START);
   localparam logic [HTIMING_W-1:0] HSyncEnd   = HTIMING_W'(H_SYNC_END);
   localparam logic [VTIMING_W-1:0] VLast      = VTIMING_W'(V_TOTAL - 1);
   localparam logic [VTIMING_W-1:0] VActStart  = VTIMING_W'(V_ACT_START);
   localparam logic [VTIMING_W-1:0] VActEnd    = VTIMING_W'(V_ACT_END);
   localparam logic [VTIMING_W-1:0] VSyncStart = VTIMING_W'(V_SYNC_START);
   localparam logic [VTIMING_W-1:0] VSyncEnd   = VTIMING_W'(V_SYNC_END);

   logic [HTIMING_W-1:0] h_q, h_d;
   logic [VTIMING_W-1:0] v_q, v_d;
   logic                 hblk_q, hblk_d;
   logic                 vblk_q, vblk_d;
   logic                 cmpblk_q, cmpblk_d;
   logic                 hsync_n_q, hsync_n_d;
   logic                 vsync_n_q, vsync_n_d;
   logic                 frame_start_q, frame_start_d;
   logic                 flip_d;
   nmi_state_t           nmi_state_q, nmi_state_d;

   // Decodes use next-count values so every registered flag lines up with
   // the counters in the same cycle.
   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == HLast) begin
         h_d = '0;
         v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end

      hblk_d        = h_d[HTIMING_W-1];
      hsync_n_d     = !((h_d >= HSyncStart) && (h_d < HSyncEnd));
      vblk_d        = !((v_d >= VActStart) && (v_d < VActEnd));
      vsync_n_d     = !((v_d >= VSyncStart) && (v_d < VSyncEnd));
      cmpblk_d      = hblk_d | vblk_d;
      frame_start_d = (h_d == '0) && (v_d == VActEnd);

      flip_d = frame_start_q ? flip_ena : flip_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q           <= '0;
         v_q           <= '0;
         hblk_q        <= 1'b0;
         vblk_q        <= 1'b1;
         cmpblk_q      <= 1'b1;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         frame_start_q <= 1'b0;
         flip_q        <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         hblk_q        <= hblk_d;
         vblk_q        <= vblk_d;
         cmpblk_q      <= cmpblk_d;
         hsync_n_q     <= hsync_n_d;
         vsync_n_q     <= vsync_n_d;
         frame_start_q <= frame_start_d;
         flip_q        <= flip_d;
      end
   end

   // Clearing the mask wins over a coincident frame start.
   always_comb begin
      nmi_state_d = nmi_state_q;
      if (!nmi_ena) begin
         nmi_state_d = IDLE;
      end else if (frame_start_q) begin
         nmi_state_d = PENDING;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nmi_state_q <= IDLE;
      end else begin
         nmi_state_q <= nmi_state_d;
      end
   end

   delay_line #(
      .Width  (1),
      .Depth  (BLK2_DELAY),
      .Preset (1'b1)
   ) u_blk2_delay (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (cmpblk_q),
      .q_o   (cmpblk2)
   );

   assign htiming     = h_q;
   assign vtiming     = v_q;
   assign vtiming_f   = v_q[7:0] ^ {8{flip_q}};
   assign hblk        = hblk_q;
   assign vblk        = vblk_q;
   assign cmpblk      = cmpblk_q;
   assign hsync_n     = hsync_n_q;
   assign vsync_n     = vsync_n_q;
   assign frame_start = frame_start_q;
   assign nmi_n       = (nmi_state_q != PENDING);

endmodule
